nios_core_onchip_mem_bridge: RTL

//  Avalon-MM pipelined slave front-end sitting directly upstream of the 16K x 32 single-port
//  on-chip RAM. Registers all master commands through a 2-entry skid buffer (registered

---
 rtl/nios_core_mem_pkg.sv | 40 ++++
 rtl/nios_core_mem_skid_buf.sv | 74 +++++++
 rtl/nios_core_onchip_mem_bridge.sv | 138 +++++++++++++
 3 files changed

// File: rtl/nios_core_mem_pkg.sv
// -----------------------------------------------------------------------------
// nios_core_mem_pkg
//   Shared definitions for the Nios data-master to on-chip RAM bridge.
//   - MEM_ADDR_W / MEM_DATA_W / MEM_BE_W : default word-address, data and
//     byte-lane widths of the 16K x 32 on-chip RAM.
//   - RD_LATENCY : cycles from command accept to avs_readdatavalid.
//   - mem_cmd_t  : one buffered Avalon command (address, lanes, data, kind).
//   - make_cmd() : packs the Avalon command inputs into a mem_cmd_t.
// -----------------------------------------------------------------------------
package nios_core_mem_pkg;

   localparam int MEM_ADDR_W = 14;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = MEM_DATA_W / 8;
   localparam int RD_LATENCY = 3;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_BE_W-1:0]   be;
      logic [MEM_DATA_W-1:0] wdata;
      logic                  is_wr;
   } mem_cmd_t;

   // read & write both high is an illegal master request; it resolves to a
   // write so that the write data is never silently lost.
   function automatic mem_cmd_t make_cmd(
      input logic [MEM_ADDR_W-1:0] addr,
      input logic [MEM_BE_W-1:0]   be,
      input logic [MEM_DATA_W-1:0] wdata,
      input logic                  write
   );
      mem_cmd_t c;
      c.addr  = addr;
      c.be    = be;
      c.wdata = wdata;
      c.is_wr = write;
      return c;
   endfunction

endpackage

// File: rtl/nios_core_mem_skid_buf.sv
// -----------------------------------------------------------------------------
// nios_core_mem_skid_buf
//   Two-entry FIFO of mem_cmd_t. Entry 0 is always the head, so the head
//   fields come straight from flops. The full flag is registered and is
//   what the bridge presents as avs_waitrequest.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : write din into the FIFO (ignored when full and not popping)
//   pop          : remove the head (ignored when empty)
//   head         : current head entry
//   head_valid   : FIFO holds at least one entry
//   full         : registered, high while the FIFO holds two entries
// -----------------------------------------------------------------------------
module nios_core_mem_skid_buf
   import nios_core_mem_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  mem_cmd_t din,
   input  logic     pop,
   output mem_cmd_t head,
   output logic     head_valid,
   output logic     full
);

   mem_cmd_t   entry0;
   mem_cmd_t   entry1;
   logic [1:0] count;
   logic [1:0] count_nxt;
   logic       do_push;
   logic       do_pop;

   always_comb begin
      do_pop    = pop & (count != 2'd0);
      // A push into a full buffer is only legal when the head leaves the
      // same cycle.
      do_push   = push & ((count != 2'd2) | do_pop);
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry0 <= '0;
         entry1 <= '0;
         count  <= 2'd0;
         full   <= 1'b0;
      end else begin
         count <= count_nxt;
         full  <= (count_nxt == 2'd2);

         // Entry 0 takes the skid entry on a pop from full, otherwise the
         // incoming command whenever it becomes (or stays) the head.
         if (do_pop && (count == 2'd2))
            entry0 <= entry1;
         else if (do_push && ((count == 2'd0) || ((count == 2'd1) && do_pop)))
            entry0 <= din;

         // Entry 1 holds the second-oldest command.
         if (do_push && (((count == 2'd1) && !do_pop) || ((count == 2'd2) && do_pop)))
            entry1 <= din;
      end
   end

   assign head       = entry0;
   assign head_valid = (count != 2'd0);

endmodule

// File: rtl/nios_core_onchip_mem_bridge.sv
// -----------------------------------------------------------------------------
// nios_core_onchip_mem_bridge
//   Avalon-MM pipelined slave front-end for the 16K x 32 single-port on-chip
//   RAM. Every command goes through a 2-entry skid buffer; the head entry is
//   issued to the RAM one per cycle while freeze is low, and read data comes
//   back with a fixed 3-cycle accept-to-readdatavalid latency.
//
// Parameters
//   ADDR_W, DATA_W : must equal MEM_ADDR_W / MEM_DATA_W of nios_core_mem_pkg
//   CNT_W          : performance counter width
//
// Ports
//   clk, reset                       : clock, asynchronous active-high reset
//   avs_address/byteenable/read/write/writedata : Avalon command in
//   avs_waitrequest                  : stall, registered (forced high in reset)
//   avs_readdata, avs_readdatavalid  : read response, in request order
//   freeze                           : halts issue to the RAM, clken low
//   mem_address/byteenable/chipselect/write/writedata/clken : RAM port
//   mem_readdata                     : RAM read data, valid 1 cycle after issue
//
// Build option
//   MEM_BRIDGE_PERF_EN : adds perf_clr input and saturating perf_rd_cnt,
//                        perf_wr_cnt, perf_stall_cnt outputs.
// -----------------------------------------------------------------------------
module nios_core_onchip_mem_bridge
   import nios_core_mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W,
   parameter int CNT_W  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   avs_address,
   input  logic [DATA_W/8-1:0] avs_byteenable,
   input  logic                avs_read,
   input  logic                avs_write,
   input  logic [DATA_W-1:0]   avs_writedata,
   output logic                avs_waitrequest,
   output logic [DATA_W-1:0]   avs_readdata,
   output logic                avs_readdatavalid,
   input  logic                freeze,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
`ifdef MEM_BRIDGE_PERF_EN
   ,
   input  logic                perf_clr,
   output logic [CNT_W-1:0]    perf_rd_cnt,
   output logic [CNT_W-1:0]    perf_wr_cnt,
   output logic [CNT_W-1:0]    perf_stall_cnt
`endif
);

   // Handshake: a command transfers on every rising edge where
   // (avs_read | avs_write) is high and avs_waitrequest is low; the master
   // must hold the command stable while avs_waitrequest is high. Toward the
   // RAM, mem_chipselect is a one-cycle issue strobe and the RAM never stalls,
   // so the head leaves the buffer on every cycle it is issued.

   mem_cmd_t                cmd_in;
   mem_cmd_t                head;
   logic                    head_valid;
   logic                    full;
   logic                    accept;
   logic                    issue;
   logic [RD_LATENCY-2:0]   rd_pipe;

   // waitrequest comes from the registered full flag; reset forces it high
   // so that it drops in the very first cycle after release.
   assign avs_waitrequest = full | reset;
   assign accept          = (avs_read | avs_write) & ~avs_waitrequest;
   assign cmd_in          = make_cmd(avs_address, avs_byteenable, avs_writedata, avs_write);
   assign issue           = head_valid & ~freeze;

   nios_core_mem_skid_buf u_skid (
      .clk        (clk),
      .rst        (reset),
      .push       (accept),
      .din        (cmd_in),
      .pop        (issue),
      .head       (head),
      .head_valid (head_valid),
      .full       (full)
   );

   // RAM command fields come straight from the head flops; only the strobes
   // are qualified by freeze.
   assign mem_address    = head.addr;
   assign mem_byteenable = head.be;
   assign mem_writedata  = head.wdata;
   assign mem_chipselect = issue;
   assign mem_write      = issue & head.is_wr;
   assign mem_clken      = ~freeze;

   // rd_pipe[0]: a read was issued last cycle, so mem_readdata is valid now.
   // rd_pipe[1]: captured data is presented with avs_readdatavalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pipe      <= '0;
         avs_readdata <= '0;
      end else begin
         rd_pipe <= {rd_pipe[0], issue & ~head.is_wr};
         if (rd_pipe[0])
            avs_readdata <= mem_readdata;
      end
   end

   assign avs_readdatavalid = rd_pipe[RD_LATENCY-2];

`ifdef MEM_BRIDGE_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_rd_cnt    <= '0;
         perf_wr_cnt    <= '0;
         perf_stall_cnt <= '0;
      end else if (perf_clr) begin
         perf_rd_cnt    <= '0;
         perf_wr_cnt    <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (issue && !head.is_wr && (perf_rd_cnt != CNT_MAX))
            perf_rd_cnt <= perf_rd_cnt + 1'b1;
         if (issue && head.is_wr && (perf_wr_cnt != CNT_MAX))
            perf_wr_cnt <= perf_wr_cnt + 1'b1;
         if (avs_waitrequest && (avs_read || avs_write) && (perf_stall_cnt != CNT_MAX))
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
   end
`endif

endmodule
